// File: rtl/agu_nd.sv
// Nested-loop address generator: NLOOPS down-counting loop levels, signed jump per level,
// valid/ready handshake with one-shot or continuous passes.
module agu_nd #(
  parameter int unsigned NLOOPS = 4,
  parameter int unsigned BWADDR = 21,
  parameter int unsigned BWLEN  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BWADDR-1:0]        cfg_base,
  input  logic [NLOOPS*BWLEN-1:0]  cfg_len,
  input  logic [NLOOPS*BWADDR-1:0] cfg_jump,
  input  logic                     cfg_cont,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [BWADDR-1:0]        addr_out,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic                     addr_last
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                          state_q, state_d;
  logic [BWADDR-1:0]               addr_q, addr_d;
  logic [BWADDR-1:0]               base_q, base_d;
  logic [NLOOPS-1:0][BWLEN-1:0]    len_q, len_d;
  logic [NLOOPS-1:0][BWADDR-1:0]   jump_q, jump_d;
  logic [NLOOPS-1:0][BWLEN-1:0]    cnt_q, cnt_d;
  logic                            cont_q, cont_d;
  logic                            done_q, done_d;
  logic                            all_zero;
  logic                            found;

  always_comb begin
    all_zero = 1'b1;
    for (int k = 0; k < NLOOPS; k++) begin
      if (cnt_q[k] != '0) all_zero = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    jump_d  = jump_q;
    cnt_d   = cnt_q;
    cont_d  = cont_q;
    done_d  = 1'b0;
    found   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          base_d  = cfg_base;
          len_d   = cfg_len;
          jump_d  = cfg_jump;
          cont_d  = cfg_cont;
          cnt_d   = cfg_len;
          addr_d  = cfg_base;
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (addr_ready) begin
          if (all_zero) begin
            if (cont_q) begin
              cnt_d  = len_q;
              addr_d = base_q;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            // Step the lowest non-exhausted level; exhausted levels below it reload.
            for (int k = 0; k < NLOOPS; k++) begin
              if (!found) begin
                if (cnt_q[k] != '0) begin
                  found    = 1'b1;
                  cnt_d[k] = cnt_q[k] - 1'b1;
                  addr_d   = addr_q + jump_q[k];
                end else begin
                  cnt_d[k] = len_q[k];
                end
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      jump_q  <= '0;
      cnt_q   <= '0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      jump_q  <= jump_d;
      cnt_q   <= cnt_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign addr_valid = (state_q == StRun);
  assign addr_last  = (state_q == StRun) && all_zero;
  assign addr_out   = addr_q;
  assign done       = done_q;

endmodule

// File: tb/tb_agu_nd.sv
// Randomised bench for agu_nd; expected addresses come from a closed-form beat-index model.
module tb_agu_nd;

  localparam int unsigned NL = 4;
  localparam int unsigned BA = 21;
  localparam int unsigned BL = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [BA-1:0]     cfg_base;
  logic [NL*BL-1:0]  cfg_len;
  logic [NL*BA-1:0]  cfg_jump;
  logic              cfg_cont;
  logic              start;
  logic              stop;
  logic              busy;
  logic              done;
  logic [BA-1:0]     addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              addr_last;

  int checks = 0;
  int errors = 0;

  int unsigned   m_len [NL];
  logic [BA-1:0] m_jump [NL];
  logic [BA-1:0] m_base;

  agu_nd #(.NLOOPS(NL), .BWADDR(BA), .BWLEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_base   (cfg_base),
    .cfg_len    (cfg_len),
    .cfg_jump   (cfg_jump),
    .cfg_cont   (cfg_cont),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .done       (done),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_last  (addr_last)
  );

  always #5 clk = ~clk;

  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic longint unsigned pass_len();
    longint unsigned p = 1;
    for (int k = 0; k < NL; k++) p = p * (m_len[k] + 1);
    return p;
  endfunction

  // Level k takes a step whenever the beat index crosses a multiple of the product of the
  // lengths below it, except when the next level up steps instead.
  function automatic logic [BA-1:0] exp_addr(longint unsigned n_in);
    longint unsigned n = n_in % pass_len();
    longint unsigned p = 1;
    longint unsigned pn;
    logic [63:0] sum = 64'(m_base);
    for (int k = 0; k < NL; k++) begin
      pn  = p * (m_len[k] + 1);
      sum = sum + 64'(m_jump[k]) * ((n / p) - (n / pn));
      p   = pn;
    end
    return sum[BA-1:0];
  endfunction

  function automatic logic exp_last(longint unsigned n);
    return (n % pass_len()) == pass_len() - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_cfg();
    cfg_base = BA'($urandom);
    cfg_len  = {$urandom, $urandom};
    cfg_jump = {$urandom, $urandom, $urandom};
    cfg_cont = 1'($urandom);
  endtask

  task automatic start_run(logic cont);
    cfg_base = m_base;
    cfg_cont = cont;
    for (int k = 0; k < NL; k++) begin
      cfg_len[k*BL +: BL]  = BL'(m_len[k]);
      cfg_jump[k*BA +: BA] = m_jump[k];
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_cfg();
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Consumes nb beats; stop is raised together with the accept of beat stop_at.
  task automatic run_beats(int nb, bit rand_ready, int stop_at);
    int n = 0;
    int cyc = 0;
    bit have_prev = 0;
    logic [BA-1:0] prev_addr = '0;
    logic prev_last = 1'b0;
    logic rdy;
    while (n < nb && cyc < 2000) begin
      chk("valid_in_run", 64'(addr_valid), 64'd1);
      chk("no_done_in_run", 64'(done), 64'd0);
      if (have_prev) begin
        chk("hold_addr", 64'(addr_out), 64'(prev_addr));
        chk("hold_last", 64'(addr_last), 64'(prev_last));
      end
      rdy = rand_ready ? 1'($urandom) : 1'b1;
      if (n == stop_at) rdy = 1'b1;
      stop = (n == stop_at);
      addr_ready = rdy;
      start = 1'($urandom);
      scramble_cfg();
      if (rdy) begin
        chk("addr", 64'(addr_out), 64'(exp_addr(longint'(n))));
        chk("last", 64'(addr_last), 64'(exp_last(longint'(n))));
        have_prev = 0;
        n++;
      end else begin
        have_prev = 1;
        prev_addr = addr_out;
        prev_last = addr_last;
      end
      tick();
      start = 1'b0;
      stop = 1'b0;
      addr_ready = 1'b0;
      cyc++;
    end
    chk("beats_before_timeout", 64'(n), 64'(nb));
  endtask

  task automatic check_done();
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("valid_at_done", 64'(addr_valid), 64'd0);
    chk("addr_kept", 64'(addr_out), 64'(exp_addr(pass_len() - 1)));
    tick();
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  task automatic check_idle_no_done(string tag);
    chk({tag, "_valid"}, 64'(addr_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic set_plan_cfg();
    m_base = BA'(100);
    m_len = '{2, 1, 0, 0};
    m_jump = '{BA'(1), BA'(10), BA'($urandom), BA'($urandom)};
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    addr_ready = 1'b0;
    scramble_cfg();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(addr_valid), 64'd0);
    chk("rst_last", 64'(addr_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'(addr_out), 64'd0);

    // Plan sequence with ready held high, then with a stalling consumer.
    set_plan_cfg();
    start_run(1'b0);
    chk("first_addr", 64'(addr_out), 64'd100);
    run_beats(6, 0, -1);
    check_done();
    set_plan_cfg();
    start_run(1'b0);
    run_beats(6, 1, -1);
    check_done();

    // Negative jump wrapping through zero.
    m_base = BA'(5);
    m_len = '{3, 0, 0, 0};
    m_jump = '{BA'(-2), BA'($urandom), BA'($urandom), BA'($urandom)};
    start_run(1'b0);
    run_beats(4, 1, -1);
    check_done();

    // Continuous passes wrap to base with no bubble, then stop.
    m_base = '0;
    m_len = '{1, 1, 0, 0};
    m_jump = '{BA'(4), BA'(100), BA'($urandom), BA'($urandom)};
    start_run(1'b1);
    run_beats(11, 1, -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_no_done("cont_stop");

    // Stop together with the accept of the 3rd beat, then restart from base.
    set_plan_cfg();
    start_run(1'b0);
    run_beats(3, 1, 2);
    check_idle_no_done("stop3");
    tick();
    check_idle_no_done("stop3_later");
    start_run(1'b0);
    run_beats(6, 0, -1);
    check_done();

    // Reset mid-run.
    set_plan_cfg();
    start_run(1'b0);
    run_beats(2, 0, -1);
    rst = 1'b1;
    addr_ready = 1'b1;
    tick();
    rst = 1'b0;
    addr_ready = 1'b0;
    check_idle_no_done("midrst");
    chk("midrst_addr", 64'(addr_out), 64'd0);
    chk("midrst_last", 64'(addr_last), 64'd0);

    // All lengths zero: one beat at base flagged last.
    m_base = BA'($urandom);
    m_len = '{0, 0, 0, 0};
    m_jump = '{BA'($urandom), BA'($urandom), BA'($urandom), BA'($urandom)};
    start_run(1'b0);
    run_beats(1, 1, -1);
    check_done();

    // Random shapes and jumps.
    for (int r = 0; r < 6; r++) begin
      m_base = BA'($urandom);
      for (int k = 0; k < NL; k++) begin
        m_len[k] = $urandom_range(0, 2);
        m_jump[k] = BA'($urandom);
      end
      start_run(1'b0);
      run_beats(int'(pass_len()), 1, -1);
      check_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
